// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if: control and status bundle for mod_updown_counter.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic en, up_dn, clr, load;
  logic [WIDTH-1:0] load_val, q;
  logic tc, wrap;
  modport master(output en, up_dn, clr, load, load_val, input q, tc, wrap);
  modport slave(input en, up_dn, clr, load, load_val, output q, tc, wrap);
endinterface

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-MODULUS up/down counter with clear, clamped load, tc and wrap pulse.
// Define MOD_UPDOWN_COUNTER_SATURATE_EN to saturate at the boundaries instead of wrapping.
module mod_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16
) (
  input logic clk,
  input logic reset,
  mod_updown_counter_if.slave bus
);
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q, q_nxt, q_up, q_dn, ld_val;
  logic wrap, wrap_nxt, at_top, at_zero;
  assign at_top = q >= TOP;
  assign at_zero = q == '0;
  assign ld_val = bus.load_val >= TOP ? TOP : bus.load_val;
  // out-of-range q behaves as the terminal value: up restarts, down resumes from TOP
  assign q_up = at_top ? (SAT ? TOP : '0) : q + 1'b1;
  assign q_dn = at_zero ? (SAT ? '0 : TOP) : (at_top && q != TOP) ? TOP : q - 1'b1;
  always_comb begin
    q_nxt = q;
    wrap_nxt = 1'b0;
    if (bus.clr) q_nxt = '0;
    else if (bus.load) q_nxt = ld_val;
    else if (bus.en) begin
      q_nxt = bus.up_dn ? q_up : q_dn;
      wrap_nxt = !SAT && (bus.up_dn ? at_top : at_zero);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q <= '0;
      wrap <= 1'b0;
    end else begin
      q <= q_nxt;
      wrap <= wrap_nxt;
    end
  assign bus.q = q;
  assign bus.wrap = wrap;
  assign bus.tc = bus.en & (bus.up_dn ? q == TOP : at_zero);
endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous modulo-N up/down counter; next generation of the team's 4-bit enable-chained synchronous counter.
- Adds generic width and modulus, direction control, synchronous clear, parallel load, terminal-count and wrap flags.
- Used as a building block for dividers, timers and cascaded BCD/multi-digit counters (tc of one stage drives en of the next).

Parameters:
- WIDTH, 4, counter register width in bits (>=1).
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; counts one step per clk when high.
- up_dn  input  1  direction: 1 = up, 0 = down.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational: en & (up_dn ? q==MODULUS-1 : q==0).
- wrap  output  1  registered one-cycle pulse, high in the cycle after q wrapped.

Behaviour:
- Reset: reset=1 forces q=0 and wrap=0 immediately, independent of clk. Deassertion takes effect at the next rising clk edge. Reset mid-count discards the count with no wrap pulse.
- Per rising clk, priority clr > load > en:
  - clr=1: q<=0, wrap<=0.
  - else load=1: q<=load_val if load_val<=MODULUS-1, else q<=MODULUS-1 (clamp). wrap<=0. en is ignored that cycle.
  - else en=1, up_dn=1: q<=(q==MODULUS-1) ? 0 : q+1. wrap<=(q==MODULUS-1).
  - else en=1, up_dn=0: q<=(q==0) ? MODULUS-1 : q-1. wrap<=(q==0).
  - else: hold q, wrap<=0.
- Latency: q updates one cycle after the qualifying edge. tc is valid in the same cycle as q/en/up_dn. wrap is exactly one cycle wide, aligned with the new q value.
- Direction change takes effect on the same edge as the new up_dn value; no extra cycle.
- Arithmetic is computed in WIDTH bits. When MODULUS==2**WIDTH, natural overflow must still yield the same wrap and tc results.
- Cascading: tc depends on en, so chaining en_next = tc gives a carry-ripple-free synchronous cascade.
- No illegal states are reachable. Any q>MODULUS-1 (impossible except via X) is treated as the terminal value on the next count.

Optional Feature:
- Macro: MOD_UPDOWN_COUNTER_SATURATE_EN.
- Defined: counter saturates instead of wrapping.
  - Up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - wrap is tied 0.
  - tc still asserts at the boundary while en=1, so a held terminal value keeps tc high.
  - clr and load are unchanged.
- Undefined: modulo wrap-around behaviour as above.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset then en=1, up_dn=1 for 12 clocks -> q runs 0..9,0,1. tc high while q=9. wrap high for the one cycle q=0 after 9.
- Load load_val=3, then en=1, up_dn=0 for 5 clocks -> q=3,2,1,0,9,8. tc high at q=0. wrap pulses with q=9.
- load_val=14 with load=1 -> q=9 (clamped). Same cycle clr=1 and load=1 -> q=0 (clr wins).
- Count to q=6, assert reset asynchronously mid-cycle -> q=0 before the next edge. wrap=0. Counting resumes at 1 after reset deasserts.
- WIDTH=4, MODULUS=16, up for 17 clocks -> q wraps 15->0 with one wrap pulse. Two chained instances (en2=tc1) -> second stage increments exactly once per 16 clocks.
- With MOD_UPDOWN_COUNTER_SATURATE_EN: up from 8 for 4 clocks -> q=9,9,9,9. wrap stays 0. tc stays high. Down from 1 -> q=0 and holds.
